// File: rtl/btn_pkg.sv
// Shared encodings for the push-button conditioner: channel FSM states and
// the bit position of each Nexys4 button within the channel vectors.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_WAIT = 3'd1,
    PRESS_ACK  = 3'd2,
    HELD       = 3'd3,
    REPEAT     = 3'd4,
    REL_WAIT   = 3'd5
  } btn_state_t;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the raw pins / game logic (master) and the
// conditioner (slave).
interface btn_conditioner_if #(
  parameter int N_BTN = 5
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] evt_ack;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;
  logic [N_BTN-1:0] btn_evt;

  modport master (
    output btn_in, evt_ack,
    input  btn_level, btn_press, btn_release, btn_repeat, btn_evt
  );

  modport slave (
    input  btn_in, evt_ack,
    output btn_level, btn_press, btn_release, btn_repeat, btn_evt
  );
endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM with a
// shared counter, registered strobes and a sticky event flag with acknowledge.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 26,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_ack,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_evt
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             r_sync1, r_sync2;
  btn_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_level, r_press, r_release, r_repeat, r_evt;
  logic             w_press_next, w_release_next, w_repeat_next, w_level_next;
  logic             w_btn_s;

  assign w_btn_s = r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_repeat  <= w_repeat_next;
    end
  end

  // Strobes are decided on the transition so they register into the cycle
  // the FSM occupies PRESS_ACK or the cycle after a counter terminal.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_repeat_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_btn_s) w_state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next  = PRESS_ACK;
          w_cnt_next    = '0;
          w_press_next  = 1'b1;
          w_repeat_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      PRESS_ACK: begin
        w_state_next = HELD;
        w_cnt_next   = '0;
      end
      HELD: begin
        if (!w_btn_s) begin
          w_state_next = REL_WAIT;
          w_cnt_next   = '0;
        end else if (REPEAT_EN) begin
          if (r_cnt == DLY_LAST) begin
            w_state_next  = REPEAT;
            w_cnt_next    = '0;
            w_repeat_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!w_btn_s) begin
          w_state_next = REL_WAIT;
          w_cnt_next   = '0;
        end else if (r_cnt == PER_LAST) begin
          w_cnt_next    = '0;
          w_repeat_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      REL_WAIT: begin
        if (w_btn_s) begin
          w_state_next = HELD;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next   = IDLE;
          w_cnt_next     = '0;
          w_release_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_level_next = (w_state_next == PRESS_ACK) || (w_state_next == HELD) ||
                        (w_state_next == REPEAT)    || (w_state_next == REL_WAIT);

  // Set has priority over acknowledge so a strobe landing with an ack is kept.
  always_ff @(posedge clk) begin
    if (rst)           r_evt <= 1'b0;
    else if (r_repeat) r_evt <= 1'b1;
    else if (i_ack)    r_evt <= 1'b0;
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;
  assign o_evt     = r_evt;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner for the Nexys4 buttons: N_BTN fully independent
// btn_channel instances, each with its own auto-repeat enable bit.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int             N_BTN           = 5,
  parameter int             DEBOUNCE_CYCLES = 1000000,
  parameter int             REPEAT_DELAY    = 50000000,
  parameter int             REPEAT_PERIOD   = 10000000,
  parameter logic [N_BTN-1:0] REPEAT_EN     = 5'b11110,
  parameter int             CNT_W           = 26
) (
  input  logic               clk,
  input  logic               rst,
  btn_conditioner_if.slave   bus
);

  logic [N_BTN-1:0] w_level, w_press, w_release, w_repeat, w_evt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W),
      .REPEAT_EN       (REPEAT_EN[i])
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (bus.btn_in[i]),
      .i_ack     (bus.evt_ack[i]),
      .o_level   (w_level[i]),
      .o_press   (w_press[i]),
      .o_release (w_release[i]),
      .o_repeat  (w_repeat[i]),
      .o_evt     (w_evt[i])
    );
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.btn_repeat  = w_repeat;
  assign bus.btn_evt     = w_evt;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing constants
// (debounce 4, repeat delay 10, repeat period 5).
module tb_btn_conditioner;
  import btn_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  btn_conditioner_if #(.N_BTN(5)) bus ();

  btn_conditioner #(
    .N_BTN           (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5),
    .REPEAT_EN       (5'b11110),
    .CNT_W           (26)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge, the point where stimulus changes.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.btn_in  = '0;
    bus.evt_ack = '0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    logic [24:0] all_out;
    rst = 1'b1;
    bus.btn_in  = '1;
    bus.evt_ack = '0;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      all_out = {bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_repeat, bus.btn_evt};
      checks++;
      if (all_out !== 25'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h, expected %h", k, all_out, 25'd0);
      end
      next_cycle();
    end
    rst = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (bus.btn_press !== ((k == 7) ? 5'b11111 : 5'b00000)) begin
        errors++;
        $display("[TB] FAIL reset_release_press cycle %0d: got %b, expected %b",
                 k, bus.btn_press, (k == 7) ? 5'b11111 : 5'b00000);
      end
      next_cycle();
    end
  endtask

  task automatic test_press_ack();
    logic e_press, e_rep, e_lvl, e_evt;
    do_reset();
    for (int k = 0; k <= 21; k++) begin
      bus.btn_in[BTN_U]  = 1'b1;
      bus.evt_ack[BTN_U] = (k == 3) || (k == 18) || (k == 19);
      @(negedge clk);
      e_press = (k == 7);
      e_rep   = (k == 7) || (k == 18);
      e_lvl   = (k >= 7);
      e_evt   = (k >= 8) && (k <= 19);
      checks++;
      if (bus.btn_press[BTN_U] !== e_press) begin
        errors++;
        $display("[TB] FAIL press_u cycle %0d: got %b, expected %b", k, bus.btn_press[BTN_U], e_press);
      end
      checks++;
      if (bus.btn_repeat[BTN_U] !== e_rep) begin
        errors++;
        $display("[TB] FAIL repeat_u cycle %0d: got %b, expected %b", k, bus.btn_repeat[BTN_U], e_rep);
      end
      checks++;
      if (bus.btn_level[BTN_U] !== e_lvl) begin
        errors++;
        $display("[TB] FAIL level_u cycle %0d: got %b, expected %b", k, bus.btn_level[BTN_U], e_lvl);
      end
      checks++;
      if (bus.btn_evt[BTN_U] !== e_evt) begin
        errors++;
        $display("[TB] FAIL evt_u cycle %0d: got %b, expected %b", k, bus.btn_evt[BTN_U], e_evt);
      end
      next_cycle();
    end
    bus.evt_ack = '0;
  endtask

  task automatic test_bounce();
    logic e_press, e_lvl;
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      bus.btn_in[BTN_D] = (k < 2) || (k >= 4 && k < 6) || (k >= 20);
      @(negedge clk);
      e_press = (k == 27);
      e_lvl   = (k >= 27);
      checks++;
      if (bus.btn_press[BTN_D] !== e_press) begin
        errors++;
        $display("[TB] FAIL bounce_press cycle %0d: got %b, expected %b", k, bus.btn_press[BTN_D], e_press);
      end
      checks++;
      if (bus.btn_level[BTN_D] !== e_lvl) begin
        errors++;
        $display("[TB] FAIL bounce_level cycle %0d: got %b, expected %b", k, bus.btn_level[BTN_D], e_lvl);
      end
      checks++;
      if (bus.btn_release[BTN_D] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce_release cycle %0d: got %b, expected 0", k, bus.btn_release[BTN_D]);
      end
      next_cycle();
    end
  endtask

  task automatic test_auto_repeat();
    logic e_rep_l, e_rep_c;
    do_reset();
    for (int k = 0; k <= 44; k++) begin
      bus.btn_in[BTN_L] = (k < 40);
      bus.btn_in[BTN_C] = (k < 40);
      @(negedge clk);
      e_rep_l = (k == 7) || (k == 18) || (k == 23) || (k == 28) || (k == 33) || (k == 38);
      e_rep_c = (k == 7);
      checks++;
      if (bus.btn_repeat[BTN_L] !== e_rep_l) begin
        errors++;
        $display("[TB] FAIL repeat_l cycle %0d: got %b, expected %b", k, bus.btn_repeat[BTN_L], e_rep_l);
      end
      checks++;
      if (bus.btn_repeat[BTN_C] !== e_rep_c) begin
        errors++;
        $display("[TB] FAIL repeat_c_disabled cycle %0d: got %b, expected %b", k, bus.btn_repeat[BTN_C], e_rep_c);
      end
      next_cycle();
    end
  endtask

  task automatic test_release_glitch();
    logic e_press, e_rel, e_lvl;
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      bus.btn_in[BTN_C] = (k < 12) || (k >= 14 && k < 20);
      @(negedge clk);
      e_press = (k == 7);
      e_rel   = (k == 27);
      e_lvl   = (k >= 7) && (k < 27);
      checks++;
      if (bus.btn_press[BTN_C] !== e_press) begin
        errors++;
        $display("[TB] FAIL glitch_press cycle %0d: got %b, expected %b", k, bus.btn_press[BTN_C], e_press);
      end
      checks++;
      if (bus.btn_release[BTN_C] !== e_rel) begin
        errors++;
        $display("[TB] FAIL glitch_release cycle %0d: got %b, expected %b", k, bus.btn_release[BTN_C], e_rel);
      end
      checks++;
      if (bus.btn_level[BTN_C] !== e_lvl) begin
        errors++;
        $display("[TB] FAIL glitch_level cycle %0d: got %b, expected %b", k, bus.btn_level[BTN_C], e_lvl);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] e_strobe, e_lvl, e_evt;
    do_reset();
    for (int k = 0; k <= 35; k++) begin
      bus.btn_in[BTN_U] = 1'b1;
      rst = (k == 20);
      @(negedge clk);
      if (k >= 21) begin
        e_strobe = (k == 28) ? 5'b00010 : 5'b00000;
        e_lvl    = (k >= 28) ? 5'b00010 : 5'b00000;
        e_evt    = (k >= 29) ? 5'b00010 : 5'b00000;
        checks++;
        if (bus.btn_press !== e_strobe) begin
          errors++;
          $display("[TB] FAIL midhold_press cycle %0d: got %b, expected %b", k, bus.btn_press, e_strobe);
        end
        checks++;
        if (bus.btn_repeat !== e_strobe) begin
          errors++;
          $display("[TB] FAIL midhold_repeat cycle %0d: got %b, expected %b", k, bus.btn_repeat, e_strobe);
        end
        checks++;
        if (bus.btn_level !== e_lvl) begin
          errors++;
          $display("[TB] FAIL midhold_level cycle %0d: got %b, expected %b", k, bus.btn_level, e_lvl);
        end
        checks++;
        if (bus.btn_evt !== e_evt) begin
          errors++;
          $display("[TB] FAIL midhold_evt cycle %0d: got %b, expected %b", k, bus.btn_evt, e_evt);
        end
        checks++;
        if (bus.btn_release !== 5'b00000) begin
          errors++;
          $display("[TB] FAIL midhold_release cycle %0d: got %b, expected %b", k, bus.btn_release, 5'b00000);
        end
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.btn_in  = '0;
    bus.evt_ack = '0;
    test_reset();
    test_press_ack();
    test_bounce();
    test_auto_repeat();
    test_release_glitch();
    test_reset_mid_hold();
    bus.btn_in = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Conditions the raw Nexys4 push-buttons before they reach the game-logic block controller. Per channel it provides:
- 2-flop synchronization and stable-time debounce;
- a debounced level, single-cycle press and release strobes, and auto-repeat strobes while held;
- a sticky event flag with acknowledge, so consumers on the slow move clock never miss a strobe generated in the 100 MHz domain.

Parameters:
N_BTN, 5, number of button channels; bit order [0]=C, [1]=U, [2]=D, [3]=L, [4]=R
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a press or release (10 ms at 100 MHz)
REPEAT_DELAY, 50000000, held cycles after the press strobe before the first repeat strobe
REPEAT_PERIOD, 10000000, cycles between subsequent repeat strobes
REPEAT_EN, 5'b11110, per-channel auto-repeat enable mask
CNT_W, 26, counter width; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
clk  input  1  system clock (ClkPort, 100 MHz)
rst  input  1  synchronous, active-high reset
btn_in  input  N_BTN  raw asynchronous button pins, active-high
btn_level  output  N_BTN  debounced button state
btn_press  output  N_BTN  1-cycle strobe on accepted press
btn_release  output  N_BTN  1-cycle strobe on accepted release
btn_repeat  output  N_BTN  1-cycle strobe on press and on each auto-repeat
btn_evt  output  N_BTN  sticky flag; set by any btn_repeat strobe
evt_ack  input  N_BTN  clears the matching btn_evt bit

Behaviour:
- Reset: rst sampled on a clk edge; all outputs 0, every FSM in IDLE, counters 0, synchronizer flops 0. Reset mid-count or mid-hold abandons the event; no strobes are emitted during the reset cycle or the cycle after it.
- Synchronizer: two flops per channel produce btn_s; input-to-btn_s latency is 2 cycles. Every FSM uses only btn_s.
- Per-channel FSM, with one CNT_W counter per channel:
  - IDLE: cnt=0. If btn_s=1, go to PRESS_WAIT.
  - PRESS_WAIT: if btn_s=0, go to IDLE (bounce rejected). Otherwise cnt++. When cnt==DEBOUNCE_CYCLES-1, go to PRESS_ACK and clear cnt.
  - PRESS_ACK (1 cycle): btn_press=1, btn_repeat=1, btn_level=1. Go to HELD.
  - HELD: if btn_s=0, go to REL_WAIT with cnt=0. Otherwise, if REPEAT_EN[i]=1, count; when cnt==REPEAT_DELAY-1, pulse btn_repeat, clear cnt, go to REPEAT.
  - REPEAT: if btn_s=0, go to REL_WAIT. Otherwise, when cnt==REPEAT_PERIOD-1, pulse btn_repeat and clear cnt; this continues indefinitely.
  - REL_WAIT: btn_level stays 1. If btn_s=1, return to HELD with cnt=0 (repeat timing restarts, no new press strobe). When cnt==DEBOUNCE_CYCLES-1, pulse btn_release, drop btn_level, go to IDLE.
- Outputs are registered. Strobes assert in the cycle the FSM is in PRESS_ACK, or on the counter-terminal cycle. Latency from a clean input edge to btn_press is 2 + DEBOUNCE_CYCLES + 1 cycles.
- btn_level rises on the PRESS_ACK cycle and falls on the btn_release cycle.
- btn_evt[i] is registered:
  - set when btn_repeat[i] is 1;
  - cleared when evt_ack[i] is 1;
  - simultaneous set and ack: set wins, so the event is never lost;
  - evt_ack with btn_evt=0 has no effect.
- Channels are fully independent. Simultaneous presses each produce their own strobes in the same cycle.
- Counters never wrap: terminal compares happen before overflow, which the CNT_W constraint guarantees.

Decomposition:
- Shared package btn_pkg: state encoding (IDLE, PRESS_WAIT, PRESS_ACK, HELD, REPEAT, REL_WAIT as 3-bit localparams) and the channel index constants BTN_C/U/D/L/R.
- Sub-module btn_channel: synchronizer, FSM, counter and evt flag for one channel. btn_conditioner instantiates it N_BTN times via generate, passing REPEAT_EN[i].

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.)
- Clean press: btn_in[1] rises at cycle 0 and is held -> btn_press[1]=btn_repeat[1]=1 for exactly cycle 7 only, btn_level[1]=1 from cycle 7, btn_evt[1]=1 from cycle 8.
- Bounce rejection: btn_in[2] toggles 1,0,1,0 every 2 cycles, then stays 0 -> no strobe, btn_level[2] stays 0, FSM back in IDLE.
- Auto-repeat: hold btn_in[3] for 40 cycles -> btn_repeat[3] pulses at cycles 7, 18, 23, 28, 33, 38. Hold btn_in[0] (REPEAT_EN=0) the same way -> a single pulse at cycle 7.
- Release glitch then release: while held, drop btn_in for 2 cycles then restore -> no btn_release, btn_level stays 1. Final drop -> btn_release 1 cycle, 2+4+1 cycles later btn_level=0.
- Ack race: assert evt_ack[1] in the same cycle as a btn_repeat[1] pulse -> btn_evt[1] stays 1. Ack one cycle later with no strobe -> btn_evt[1]=0 the next cycle.
- Reset mid-hold: rst=1 for 1 cycle while in REPEAT with button still held -> all outputs 0. The next btn_press occurs 2+4+1 cycles after rst deasserts, with no stale repeat strobe.
